// File: rtl/temp_poll_ctrl_if.sv
// rtl/temp_poll_ctrl_if.sv - read handshake between temp_poll_ctrl and the I2C sensor read engine
interface temp_poll_ctrl_if;
  logic       rd_req;
  logic       rd_done;
  logic       rd_nack;
  logic [7:0] rd_data;

  modport master (output rd_req, input rd_done, input rd_nack, input rd_data);
  modport slave  (input rd_req, output rd_done, output rd_nack, output rd_data);
endinterface

// File: rtl/temp_poll_ctrl.sv
// rtl/temp_poll_ctrl.sv - periodic temperature poller with timeout, error count and hysteretic alarm
// Define TEMP_POLL_AVG_EN to filter temp_out with a 4-sample moving average.
module temp_poll_ctrl #(
  parameter int unsigned POLL_DIV = 20000,
  parameter int unsigned TIMEOUT  = 1000,
  parameter logic [7:0]  ALARM_HI = 8'd40,
  parameter logic [7:0]  ALARM_LO = 8'd35
) (
  input  logic             clk_200KHz,
  input  logic             rst_n,
  input  logic             enable,
  temp_poll_ctrl_if.master rd,
  output logic [7:0]       temp_out,
  output logic             temp_valid,
  output logic             over_temp,
  output logic [7:0]       err_count,
  output logic             busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0]   DIV_LAST = 16'(POLL_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT, REQ, XFER, UPDATE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   ivl_q, ivl_d;
  logic [TW-1:0] to_q, to_d;
  logic          rd_req_q, rd_req_d;
  logic [7:0]    cap_data_q, cap_data_d;
  logic          cap_nack_q, cap_nack_d;
  logic [7:0]    temp_q, temp_d;
  logic          valid_q, valid_d;
  logic          over_q, over_d;
  logic [7:0]    err_q, err_d;
  logic          busy_q, busy_d;
  logic          err_inc;

`ifdef TEMP_POLL_AVG_EN
  logic [3:0][7:0] hist_q, hist_d;

  // Floor of the signed mean: arithmetic shift of the 10-bit sum.
  function automatic logic [7:0] avg4(input logic [3:0][7:0] h);
    logic signed [9:0] s;
    s = 10'($signed(h[0])) + 10'($signed(h[1])) + 10'($signed(h[2])) + 10'($signed(h[3]));
    return 8'(s >>> 2);
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    ivl_d      = ivl_q;
    to_d       = to_q;
    cap_data_d = cap_data_q;
    cap_nack_d = cap_nack_q;
    temp_d     = temp_q;
    valid_d    = valid_q;
    over_d     = over_q;
    err_d      = err_q;
    err_inc    = 1'b0;
`ifdef TEMP_POLL_AVG_EN
    hist_d     = hist_q;
`endif

    case (state_q)
      IDLE: begin
        ivl_d = '0;
        if (enable) state_d = REQ;
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
          ivl_d   = '0;
        end else if (ivl_q == DIV_LAST) begin
          state_d = REQ;
          ivl_d   = '0;
        end else begin
          ivl_d = ivl_q + 16'd1;
        end
      end
      REQ: begin
        to_d    = '0;
        state_d = XFER;
      end
      XFER: begin
        // A response on the last allowed cycle still counts as a response.
        if (rd.rd_done) begin
          cap_data_d = rd.rd_data;
          cap_nack_d = rd.rd_nack;
          state_d    = UPDATE;
        end else if (to_q == TO_LAST) begin
          err_inc = 1'b1;
          ivl_d   = '0;
          state_d = WAIT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      UPDATE: begin
        if (cap_nack_q) begin
          err_inc = 1'b1;
        end else begin
          valid_d = 1'b1;
`ifdef TEMP_POLL_AVG_EN
          if (!valid_q) hist_d = {4{cap_data_q}};
          else          hist_d = {hist_q[2:0], cap_data_q};
          temp_d = avg4(hist_d);
`else
          temp_d = cap_data_q;
`endif
        end
        ivl_d   = '0;
        state_d = enable ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;

    // temp_q only moves on leaving UPDATE, so this lands one cycle after it.
    if (valid_q) begin
      if ($signed(temp_q) >= $signed(ALARM_HI))      over_d = 1'b1;
      else if ($signed(temp_q) <= $signed(ALARM_LO)) over_d = 1'b0;
    end

    rd_req_d = (state_d == REQ);
    busy_d   = (state_d == REQ) || (state_d == XFER) || (state_d == UPDATE);
  end

  always_ff @(posedge clk_200KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ivl_q      <= '0;
      to_q       <= '0;
      rd_req_q   <= 1'b0;
      cap_data_q <= '0;
      cap_nack_q <= 1'b0;
      temp_q     <= '0;
      valid_q    <= 1'b0;
      over_q     <= 1'b0;
      err_q      <= '0;
      busy_q     <= 1'b0;
`ifdef TEMP_POLL_AVG_EN
      hist_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ivl_q      <= ivl_d;
      to_q       <= to_d;
      rd_req_q   <= rd_req_d;
      cap_data_q <= cap_data_d;
      cap_nack_q <= cap_nack_d;
      temp_q     <= temp_d;
      valid_q    <= valid_d;
      over_q     <= over_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
`ifdef TEMP_POLL_AVG_EN
      hist_q     <= hist_d;
`endif
    end
  end

  assign rd.rd_req  = rd_req_q;
  assign temp_out   = temp_q;
  assign temp_valid = valid_q;
  assign over_temp  = over_q;
  assign err_count  = err_q;
  assign busy       = busy_q;

endmodule
